post_adder_carryout: RTL and testbench
======================================

Name: post_adder_carryout

Overview:
- Post-adder/subtracter and carry-out stage of the DSP48A1 slice.
- Consumes the X and Z multiplexer outputs and the registered carry-in CIN.
- Produces P, PCOUT, CARRYOUT and CARRYOUTF through optional pipeline registers.
- Carry-out end of the carry path: CIN enters, CARRYOUT leaves towards the next slice.

Parameters:
- WIDTH, 48, datapath width of X, Z and P.
- PREG, 1, 1 = P/PCOUT registered, 0 = combinational.
- CARRYOUTREG, 1, 1 = CARRYOUT/CARRYOUTF registered, 0 = combinational.

Ports:
- CLK  input  1  slice clock, rising edge.
- RSTP  input  1  synchronous, active-low reset for the P and carry-out registers.
- X  input  WIDTH  X-mux output.
- Z  input  WIDTH  Z-mux output.
- CIN  input  1  carry-in from the carry-in register.
- OPMODE7  input  1  0 = add, 1 = subtract.
- CEP  input  1  clock enable, P register.
- CECARRYOUT  input  1  clock enable, carry-out register.
- P  output  WIDTH  result.
- PCOUT  output  WIDTH  cascade copy of P.
- CARRYOUT  output  1  carry/borrow to the next slice.
- CARRYOUTF  output  1  fabric copy of CARRYOUT.

Behaviour:
- Arithmetic uses WIDTH+1-bit unsigned operands, S = {1'b0,Z} op ({1'b0,X} + CIN).
  - OPMODE7=0: S = Z + X + CIN.
  - OPMODE7=1: S = Z - (X + CIN).
- Result: RES = S[WIDTH-1:0]; COUT = S[WIDTH].
  - Add: COUT is the true carry.
  - Subtract: COUT is 1 on borrow.
- P register (PREG=1):
  - On each CLK edge, RSTP=0 loads 0; else CEP=1 loads RES; else holds.
  - Latency 1 cycle.
- Carry-out register (CARRYOUTREG=1):
  - On each CLK edge, RSTP=0 loads 0; else CECARRYOUT=1 loads COUT; else holds.
  - Latency 1 cycle.
- PREG=0 or CARRYOUTREG=0: the corresponding outputs follow RES/COUT combinationally. RSTP and the CE inputs have no effect on that path.
- PCOUT == P and CARRYOUTF == CARRYOUT at all times.
- Reset values: P, PCOUT, CARRYOUT, CARRYOUTF = 0 at the first edge with RSTP=0.
- Reset has priority over CE. Reset asserted mid-stream clears on that edge, and the outputs are 0 the following cycle.
- CEP and CECARRYOUT are independent. Asserting only one updates only its register.
- Wrap-around: the sum modulo 2^WIDTH is kept in P. No saturation.
- Both registers are built from dff_mux instances (size WIDTH / 1; pipeline = PREG / CARRYOUTREG).
- The active-low reset is inverted locally before dff_mux.

Optional Feature:
- Macro: POST_ADDER_PATTERN_DETECT_EN.
- When defined:
  - Adds input PATTERN[WIDTH-1:0] and output PATTERNDETECT[1].
  - PATTERNDETECT = (RES == PATTERN).
  - It is registered alongside P: same PREG, CEP and RSTP rules, reset value 0.
- When undefined: neither port exists and the behaviour is unchanged.

Decomposition:
- Shared package dsp48a1_pkg:
  - WIDTH_P = 48.
  - OPMODE7 encodings OP_ADD = 1'b0, OP_SUB = 1'b1.
- Sub-module: reuse the existing dff_mux for both registers. No new sub-module.
- The arithmetic stays inline.

Test Plan:
- Basic add, PREG=1: RSTP=1, CEP=CECARRYOUT=1, OPMODE7=0, Z=48'h1, X=48'h2, CIN=1 -> next cycle P=48'h4, CARRYOUT=0.
- Overflow: Z=48'hFFFF_FFFF_FFFF, X=48'h1, CIN=0, add -> P=0, CARRYOUT=1, CARRYOUTF=1, PCOUT=0.
- Subtract/borrow: OPMODE7=1, Z=48'h5, X=48'h7, CIN=0 -> P=48'hFFFF_FFFF_FFFE, CARRYOUT=1. Then Z=48'h9 -> P=48'h2, CARRYOUT=0.
- CE hold: load P=48'h4, then CEP=0 with new operands -> P stays 48'h4. With CECARRYOUT=1 and an overflow input, CARRYOUT goes 1 while P holds.
- Reset priority: RSTP=0 with CEP=1 and nonzero operands -> next cycle P=0, CARRYOUT=0. RSTP back to 1 -> the result appears one cycle later.
- Combinational mode: PREG=CARRYOUTREG=0, Z=48'h10, X=48'h1, add -> P=48'h11 in the same cycle with no clock edge. RSTP=0 has no effect.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice model: datapath width and OPMODE7 encodings.
// No logic, no latency.
// No flow control; constants only.
package dsp48a1_pkg;

  // Natural width of the P datapath in the slice
  localparam int WIDTH_P = 48;

  // OPMODE[7] selects the post-adder operation
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : dsp48a1_pkg

// File: rtl/dff_mux.sv
// Optional pipeline register: a clock-enabled flop with synchronous active-high reset, or a wire.
// Latency: 1 cycle when PIPELINE=1, 0 when PIPELINE=0.
// No backpressure; ce=0 holds the stored value, rst beats ce.
module dff_mux #(
  parameter int SIZE     = 1,
  parameter int PIPELINE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  generate
    if (PIPELINE != 0) begin : g_reg
      logic [SIZE-1:0] q_r;

      // Register stage: reset has priority, then enable, otherwise hold
      always_ff @(posedge clk) begin
        if (rst) begin
          q_r <= '0;
        end else if (ce) begin
          q_r <= d;
        end
      end

      assign q = q_r;
    end else begin : g_bypass
      // Clock, reset and enable are meaningless on a bypassed stage
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, ce};

      assign q = d;
    end
  endgenerate

endmodule : dff_mux

// File: rtl/post_adder_carryout.sv
// Post-adder/subtracter and carry-out stage of the DSP48A1 slice (optional POST_ADDER_PATTERN_DETECT_EN).
// Latency: PREG / CARRYOUTREG cycles (1 each by default, 0 when bypassed).
// No backpressure; CEP and CECARRYOUT independently hold their registers.
module post_adder_carryout
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH       = WIDTH_P,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic             CLK,
  input  logic             RSTP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Z,
  input  logic             CIN,
  input  logic             OPMODE7,
  input  logic             CEP,
  input  logic             CECARRYOUT,
`ifdef POST_ADDER_PATTERN_DETECT_EN
  input  logic [WIDTH-1:0] PATTERN,
  output logic             PATTERNDETECT,
`endif
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] PCOUT,
  output logic             CARRYOUT,
  output logic             CARRYOUTF
);

  // dff_mux expects an active-high reset; the slice pin is active-low
  logic rst;
  assign rst = ~RSTP;

  // One extra bit holds the carry (add) or the borrow (subtract)
  logic [WIDTH:0]   operand;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             cout;

  // Post-adder: carry-in is folded into the X operand before the add/subtract
  always_comb begin
    operand = {1'b0, X} + {{WIDTH{1'b0}}, CIN};
    sum     = '0;
    if (OPMODE7 == OP_SUB) begin
      sum = {1'b0, Z} - operand;
    end else begin
      sum = {1'b0, Z} + operand;
    end
  end

  assign res  = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];

  logic [WIDTH-1:0] p_q;
  logic             cout_q;

  dff_mux #(
    .SIZE     (WIDTH),
    .PIPELINE (PREG)
  ) u_preg (
    .clk (CLK),
    .rst (rst),
    .ce  (CEP),
    .d   (res),
    .q   (p_q)
  );

  dff_mux #(
    .SIZE     (1),
    .PIPELINE (CARRYOUTREG)
  ) u_carryoutreg (
    .clk (CLK),
    .rst (rst),
    .ce  (CECARRYOUT),
    .d   (cout),
    .q   (cout_q)
  );

  // Cascade and fabric copies are the same nets as the primary outputs
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign CARRYOUT  = cout_q;
  assign CARRYOUTF = cout_q;

`ifdef POST_ADDER_PATTERN_DETECT_EN
  // Match is taken on the pre-register result so it lines up with P
  logic match;
  assign match = (res == PATTERN);

  dff_mux #(
    .SIZE     (1),
    .PIPELINE (PREG)
  ) u_patreg (
    .clk (CLK),
    .rst (rst),
    .ce  (CEP),
    .d   (match),
    .q   (PATTERNDETECT)
  );
`endif

endmodule : post_adder_carryout

// File: tb/tb_post_adder_carryout.sv
// Bench for post_adder_carryout: one registered and one combinational instance against a model.
// Latency: checks registered outputs at negedge, one cycle after the driven edge.
// No backpressure in the design; CE/reset behaviour is exercised directly.
module tb_post_adder_carryout;
  import dsp48a1_pkg::*;

  localparam int W = WIDTH_P;

  logic         clk = 1'b0;
  logic         rstp = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] z = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         cep = 1'b1;
  logic         cec = 1'b1;

  logic [W-1:0] p_r, pc_r, p_c, pc_c;
  logic         co_r, cf_r, co_c, cf_c;

`ifdef POST_ADDER_PATTERN_DETECT_EN
  logic [W-1:0] pattern = 48'h4;
  logic         pd_r, pd_c;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  post_adder_carryout dut_reg (
    .CLK        (clk),
    .RSTP       (rstp),
    .X          (x),
    .Z          (z),
    .CIN        (cin),
    .OPMODE7    (op),
    .CEP        (cep),
    .CECARRYOUT (cec),
`ifdef POST_ADDER_PATTERN_DETECT_EN
    .PATTERN       (pattern),
    .PATTERNDETECT (pd_r),
`endif
    .P          (p_r),
    .PCOUT      (pc_r),
    .CARRYOUT   (co_r),
    .CARRYOUTF  (cf_r)
  );

  post_adder_carryout #(
    .PREG        (0),
    .CARRYOUTREG (0)
  ) dut_comb (
    .CLK        (clk),
    .RSTP       (rstp),
    .X          (x),
    .Z          (z),
    .CIN        (cin),
    .OPMODE7    (op),
    .CEP        (cep),
    .CECARRYOUT (cec),
`ifdef POST_ADDER_PATTERN_DETECT_EN
    .PATTERN       (pattern),
    .PATTERNDETECT (pd_c),
`endif
    .P          (p_c),
    .PCOUT      (pc_c),
    .CARRYOUT   (co_c),
    .CARRYOUTF  (cf_c)
  );

  // Reference arithmetic in plain 64-bit integers: sum/difference and carry/borrow
  task automatic ref_calc(input logic [W-1:0] zv, input logic [W-1:0] xv, input logic cv,
                          input logic ov, output logic [W-1:0] r, output logic c);
    logic [63:0] zz, xx, t;
    zz = {16'h0, zv};
    xx = {16'h0, xv} + {63'h0, cv};
    if (ov) begin
      t = zz - xx;
      c = (xx > zz);
    end else begin
      t = zz + xx;
      c = (t >= 64'h0001_0000_0000_0000);
    end
    r = t[W-1:0];
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the registered instance
  logic [W-1:0] m_p = '0;
  logic         m_c = 1'b0;
  logic         m_pd = 1'b0;
  logic         m_vld = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] r;
    logic c;
    ref_calc(z, x, cin, op, r, c);
    if (!rstp) begin
      m_p   <= '0;
      m_c   <= 1'b0;
      m_pd  <= 1'b0;
      m_vld <= 1'b1;
    end else begin
      if (cep) begin
        m_p <= r;
`ifdef POST_ADDER_PATTERN_DETECT_EN
        m_pd <= (r == pattern);
`endif
      end
      if (cec) m_c <= c;
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] r;
    logic c;
    ref_calc(z, x, cin, op, r, c);
    chk("p_comb", p_c, r);
    chk("pcout_comb", pc_c, r);
    chk("carryout_comb", {47'h0, co_c}, {47'h0, c});
    chk("carryoutf_comb", {47'h0, cf_c}, {47'h0, c});
    if (m_vld) begin
      chk("p_reg", p_r, m_p);
      chk("pcout_reg", pc_r, m_p);
      chk("carryout_reg", {47'h0, co_r}, {47'h0, m_c});
      chk("carryoutf_reg", {47'h0, cf_r}, {47'h0, m_c});
    end
`ifdef POST_ADDER_PATTERN_DETECT_EN
    chk("pd_comb", {47'h0, pd_c}, {47'h0, (r == pattern)});
    if (m_vld) chk("pd_reg", {47'h0, pd_r}, {47'h0, m_pd});
`endif
  end

  task automatic drive(input logic [W-1:0] zv, input logic [W-1:0] xv, input logic cv,
                       input logic ov, input logic cepv, input logic cecv, input logic rv);
    z = zv; x = xv; cin = cv; op = ov; cep = cepv; cec = cecv; rstp = rv;
  endtask

  // Advance one edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    chk("reset_p", p_r, 48'h0);
    chk("reset_pcout", pc_r, 48'h0);
    chk("reset_carryout", {47'h0, co_r}, 48'h0);
    chk("reset_carryoutf", {47'h0, cf_r}, 48'h0);

    // Basic add
    drive(48'h1, 48'h2, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("add_p", p_r, 48'h4);
    chk("add_carryout", {47'h0, co_r}, 48'h0);

    // Overflow wraps, carry out set
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("ovf_p", p_r, 48'h0);
    chk("ovf_pcout", pc_r, 48'h0);
    chk("ovf_carryout", {47'h0, co_r}, 48'h1);
    chk("ovf_carryoutf", {47'h0, cf_r}, 48'h1);

    // Subtract with borrow, then without
    drive(48'h5, 48'h7, 1'b0, OP_SUB, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("sub_borrow_p", p_r, 48'hFFFF_FFFF_FFFE);
    chk("sub_borrow_co", {47'h0, co_r}, 48'h1);
    drive(48'h9, 48'h7, 1'b0, OP_SUB, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("sub_p", p_r, 48'h2);
    chk("sub_co", {47'h0, co_r}, 48'h0);

    // Subtract with carry-in, and X+CIN reaching 2^W
    drive(48'h8, 48'h3, 1'b1, OP_SUB, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("sub_cin_p", p_r, 48'h4);
    drive(48'h1234, 48'hFFFF_FFFF_FFFF, 1'b1, OP_SUB, 1'b1, 1'b1, 1'b1);
    cyc();
    chk("sub_full_p", p_r, 48'h1234);
    chk("sub_full_co", {47'h0, co_r}, 48'h1);

    // CE hold: P holds while carry register keeps updating
    drive(48'h1, 48'h2, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b1);
    cyc();
    drive(48'h100, 48'h5, 1'b0, OP_ADD, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("hold_p", p_r, 48'h4);
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, OP_ADD, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("hold_p2", p_r, 48'h4);
    chk("hold_co_upd", {47'h0, co_r}, 48'h1);
    // Carry register held while P updates
    drive(48'h3, 48'h3, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("hold_co_p", p_r, 48'h6);
    chk("hold_co", {47'h0, co_r}, 48'h1);

    // Reset beats CE, then result one cycle after release
    drive(48'h10, 48'h20, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("rst_prio_p", p_r, 48'h0);
    chk("rst_prio_co", {47'h0, co_r}, 48'h0);
    drive(48'h10, 48'h20, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b1);
    chk("rst_rel_still0", p_r, 48'h0);
    cyc();
    chk("rst_rel_p", p_r, 48'h30);

    // Combinational instance: no edge between drive and check, reset ignored
    drive(48'h10, 48'h1, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    #1;
    chk("comb_p", p_c, 48'h11);
    chk("comb_pcout", pc_c, 48'h11);
    rstp = 1'b0;
    #1;
    chk("comb_rst_p", p_c, 48'h11);
    z = 48'hFFFF_FFFF_FFFF;
    #1;
    chk("comb_ovf_p", p_c, 48'h0);
    chk("comb_ovf_co", {47'h0, co_c}, 48'h1);
    cyc();
    chk("comb_after_edge", p_c, 48'h0);

    drive(48'h0, 48'h0, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b1);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_post_adder_carryout
